// File: rtl/queue_pkg.sv
// queue_pkg: shared constants and helpers for the parametrised FIFO queue.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and entry count.
//   level_width(depth)            : bits needed to hold a fill level of 0..depth.
package queue_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 1024;

  // A level of exactly DEPTH must be representable, hence one extra bit.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ram_dp.sv
// ram_dp: simple dual-port RAM, one synchronous write port and one
// registered synchronous read port, shaped for block-RAM inference.
//   i_clk     : clock
//   i_rst_n   : synchronous active-low reset of the read data register only
//   i_wr_en   : write strobe
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_en   : read strobe; o_rd_data updates only when set
//   i_rd_addr : read address
//   o_rd_data : registered read data, held between reads
module ram_dp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read-before-write on an address collision: a full queue that pops and
  // pushes in the same cycle must return the old (oldest) word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/queue_param.sv
// queue_param: parametrised synchronous FIFO with fill level, programmable
// almost-full/almost-empty flags, synchronous flush and sticky error flags.
//   clk          : clock, all state changes on the rising edge
//   rest_n       : synchronous active-low reset
//   clr          : synchronous flush (pointers, level, errors to 0; RAM kept)
//   wr_en / din  : write request and data
//   rd_en        : read request
//   out          : registered read data
//   out_valid    : one-cycle pulse when out holds a newly popped word
//   empty / full : level == 0 / level == DEPTH
//   almost_empty : level <= AE_LEVEL
//   almost_full  : level >= AF_LEVEL
//   level        : number of stored entries
//   overflow     : sticky, write attempted while full without a read
//   underflow    : sticky, read attempted while empty
module queue_param
  import queue_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned LW      = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rest_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] C_AF    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] C_AE    = LW'(AE_LEVEL);
  localparam logic [LW-1:0] C_ONE   = LW'(1);
  localparam logic [AW-1:0] C_PINC  = AW'(1);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_out_valid;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_empty;
  logic          w_full;
  logic          w_run;
  logic          w_rd_acc;
  logic          w_wr_acc;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == C_DEPTH);

  // Normal operation only when out of reset and not flushing; this also
  // keeps the RAM ports idle during reset/flush cycles.
  assign w_run    = rest_n & ~clr;
  assign w_rd_acc = w_run & rd_en & ~w_empty;
  assign w_wr_acc = w_run & wr_en & (~w_full | w_rd_acc);

  ram_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk     (clk),
    .i_rst_n   (rest_n),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wptr),
    .i_wr_data (din),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rptr),
    .o_rd_data (out)
  );

  always_ff @(posedge clk) begin
    if (!rest_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_out_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wptr <= r_wptr + C_PINC;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + C_PINC;
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_level <= r_level + C_ONE;
      end else if (w_rd_acc && !w_wr_acc) begin
        r_level <= r_level - C_ONE;
      end
      if (wr_en && w_full && !w_rd_acc) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_level <= C_AE);
  assign almost_full  = (r_level >= C_AF);
  assign level        = r_level;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_queue_param.sv
// Self-checking bench for queue_param (WIDTH=8, DEPTH=1024): directed
// vector table, hand-written corner sequences and a randomized run, all
// compared against a queue-based reference model.
module tb_queue_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 1024;
  localparam int AFL   = DEPTH - 4;
  localparam int AEL   = 4;

  logic             clk = 1'b0;
  logic             rest_n = 1'b0;
  logic             clr = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [10:0]      level;
  logic             overflow;
  logic             underflow;

  queue_param #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AFL),
    .AE_LEVEL (AEL)
  ) dut (
    .clk          (clk),
    .rest_n       (rest_n),
    .clr          (clr),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .out          (out),
    .out_valid    (out_valid),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: contents as a plain queue plus the observable registers.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_out = '0;
  logic             m_vld = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  typedef struct {
    logic             wr;
    logic             rd;
    logic             cl;
    logic [WIDTH-1:0] d;
    int               lvl;
    logic [WIDTH-1:0] o;
    logic             vld;
    logic             ovf;
    logic             unf;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic rn, input logic wr, input logic rd,
                              input logic cl, input logic [WIDTH-1:0] d);
    int  sz;
    logic rok, wok;
    if (!rn) begin
      mq.delete();
      m_out = '0; m_vld = 0; m_ovf = 0; m_unf = 0;
    end else if (cl) begin
      mq.delete();
      m_vld = 0; m_ovf = 0; m_unf = 0;
    end else begin
      sz  = mq.size();
      rok = rd && (sz > 0);
      wok = wr && ((sz < DEPTH) || rok);
      m_vld = rok;
      if (rd && sz == 0) m_unf = 1;
      if (wr && !wok)    m_ovf = 1;
      if (rok) m_out = mq.pop_front();
      if (wok) mq.push_back(d);
    end
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, ".level"},        int'(level),        sz);
    chk({tag, ".empty"},        int'(empty),        int'(sz == 0));
    chk({tag, ".full"},         int'(full),         int'(sz == DEPTH));
    chk({tag, ".almost_empty"}, int'(almost_empty), int'(sz <= AEL));
    chk({tag, ".almost_full"},  int'(almost_full),  int'(sz >= AFL));
    chk({tag, ".out"},          int'(out),          int'(m_out));
    chk({tag, ".out_valid"},    int'(out_valid),    int'(m_vld));
    chk({tag, ".overflow"},     int'(overflow),     int'(m_ovf));
    chk({tag, ".underflow"},    int'(underflow),    int'(m_unf));
  endtask

  task automatic step(input string tag, input logic rn, input logic wr,
                      input logic rd, input logic cl, input logic [WIDTH-1:0] d);
    rest_n = rn; wr_en = wr; rd_en = rd; clr = cl; din = d;
    @(posedge clk);
    model_update(rn, wr, rd, cl, d);
    #1;
    check_model(tag);
  endtask

  initial begin
    // Directed table starting from a freshly reset, empty queue.
    tbl[0] = '{wr:0, rd:1, cl:0, d:8'h00, lvl:0, o:8'h00, vld:0, ovf:0, unf:1};
    tbl[1] = '{wr:1, rd:0, cl:0, d:8'h11, lvl:1, o:8'h00, vld:0, ovf:0, unf:1};
    tbl[2] = '{wr:1, rd:0, cl:0, d:8'h22, lvl:2, o:8'h00, vld:0, ovf:0, unf:1};
    tbl[3] = '{wr:1, rd:1, cl:0, d:8'h33, lvl:2, o:8'h11, vld:1, ovf:0, unf:1};
    tbl[4] = '{wr:0, rd:1, cl:0, d:8'h00, lvl:1, o:8'h22, vld:1, ovf:0, unf:1};
    tbl[5] = '{wr:1, rd:0, cl:1, d:8'h99, lvl:0, o:8'h22, vld:0, ovf:0, unf:0};
    tbl[6] = '{wr:1, rd:1, cl:0, d:8'h44, lvl:1, o:8'h22, vld:0, ovf:0, unf:1};
    tbl[7] = '{wr:0, rd:1, cl:0, d:8'h00, lvl:0, o:8'h44, vld:1, ovf:0, unf:1};
    tbl[8] = '{wr:0, rd:0, cl:0, d:8'h00, lvl:0, o:8'h44, vld:0, ovf:0, unf:1};

    // Reset held for three cycles, then released.
    for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step("post_reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("reset.empty", int'(empty), 1);
    chk("reset.level", int'(level), 0);
    chk("reset.out",   int'(out),   0);

    for (int i = 0; i < 9; i++) begin
      step("table", 1'b1, tbl[i].wr, tbl[i].rd, tbl[i].cl, tbl[i].d);
      chk($sformatf("tbl%0d.level", i),     int'(level),     tbl[i].lvl);
      chk($sformatf("tbl%0d.out", i),       int'(out),       int'(tbl[i].o));
      chk($sformatf("tbl%0d.out_valid", i), int'(out_valid), int'(tbl[i].vld));
      chk($sformatf("tbl%0d.overflow", i),  int'(overflow),  int'(tbl[i].ovf));
      chk($sformatf("tbl%0d.underflow", i), int'(underflow), int'(tbl[i].unf));
    end

    // Fill 1..1024, watching almost_full and full thresholds.
    step("flush", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int k = 1; k <= DEPTH; k++) begin
      step("fill", 1'b1, 1'b1, 1'b0, 1'b0, 8'(k));
      chk("fill.almost_full", int'(almost_full), int'(k >= 1020));
      chk("fill.full",        int'(full),        int'(k == DEPTH));
    end

    // Write while full: dropped, overflow sticks.
    step("overflow", 1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
    chk("overflow.flag",  int'(overflow), 1);
    chk("overflow.level", int'(level),    DEPTH);

    // Simultaneous read+write at full: oldest word out, level unchanged.
    step("full_rw", 1'b1, 1'b1, 1'b1, 1'b0, 8'hAA);
    chk("full_rw.out",   int'(out),   1);
    chk("full_rw.level", int'(level), DEPTH);

    // Drain: 2..1024 then the AA written into the freed slot.
    for (int k = 2; k <= DEPTH; k++) begin
      step("drain", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain.out", int'(out), k & 8'hFF);
    end
    step("drain_last", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("drain_last.out",   int'(out),   8'hAA);
    chk("drain_last.empty", int'(empty), 1);

    // Read while empty.
    step("underflow", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("underflow.flag",      int'(underflow), 1);
    chk("underflow.out_valid", int'(out_valid), 0);

    // Reset in the middle of a fill discards contents and clears out.
    for (int k = 0; k < 10; k++) step("prefill", 1'b1, 1'b1, 1'b0, 1'b0, 8'(k + 8'h30));
    step("mid_reset", 1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
    chk("mid_reset.level", int'(level), 0);
    chk("mid_reset.out",   int'(out),   0);

    // Randomized run: write-heavy, read-heavy, then balanced.
    for (int c = 0; c < 3000; c++) begin
      int pw, pr;
      logic w, r;
      if (c < 1300)      begin pw = 90; pr = 20; end
      else if (c < 2600) begin pw = 20; pr = 90; end
      else               begin pw = 50; pr = 50; end
      w = ($urandom_range(99) < pw);
      r = ($urandom_range(99) < pr);
      step("random", 1'b1, w, r, 1'b0, 8'($urandom));
      if (int'(level) > DEPTH) chk("random.level_bound", int'(level), DEPTH);
    end

    // Flush mid-operation at level 500.
    step("flush2", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 500; k++) step("fill500", 1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom));
    chk("fill500.level", int'(level), 500);
    step("clr_wr", 1'b1, 1'b1, 1'b0, 1'b1, 8'h12);
    chk("clr_wr.level",     int'(level),     0);
    chk("clr_wr.empty",     int'(empty),     1);
    chk("clr_wr.overflow",  int'(overflow),  0);
    chk("clr_wr.underflow", int'(underflow), 0);
    step("wr55", 1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
    step("rd55", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("rd55.out",       int'(out),       8'h55);
    chk("rd55.out_valid", int'(out_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
